// File: rtl/serial_alu_pkg.sv
// Shared types for the serial ALU: operation encoding, FSM states and defaults.
package serial_alu_pkg;

    localparam int ALU_WIDTH_DEFAULT = 16;
    localparam int ALU_DIGIT_DEFAULT = 4;

    // Encodings 12..15 are left unused and are reported as illegal.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLT   = 4'd2,
        ALU_SLTU  = 4'd3,
        ALU_AND   = 4'd4,
        ALU_OR    = 4'd5,
        ALU_XOR   = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_AUIPC = 4'd11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARITH = 2'd1,
        SHIFT = 2'd2,
        FIN   = 2'd3
    } serial_alu_state_t;

    // True for every encoding the ALU knows how to execute.
    function automatic logic is_legal_op(input alu_op_t op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR,
            ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_AUIPC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Ops that run the subtract datapath (inverted b, carry-in 1).
    function automatic logic is_sub_op(input alu_op_t op);
        return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
    endfunction

endpackage

// File: rtl/serial_digit_adder.sv
// Combinational DIGIT-bit adder slice with optional b inversion for subtraction.
module serial_digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             invert_b,
    input  logic             carry_in,
    output logic [DIGIT-1:0] sum,
    output logic             carry_out
);

    logic [DIGIT:0] total;

    // One digit of a + (b or ~b) + carry_in, carry out taken from the top bit.
    always_comb begin
        total     = {1'b0, a} + {1'b0, (invert_b ? ~b : b)} + {{DIGIT{1'b0}}, carry_in};
        sum       = total[DIGIT-1:0];
        carry_out = total[DIGIT];
    end

endmodule

// File: rtl/serial_alu.sv
// Digit-serial ALU: arithmetic/logic one digit per cycle, shifts one bit per cycle.
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter  int WIDTH = ALU_WIDTH_DEFAULT,
    parameter  int DIGIT = ALU_DIGIT_DEFAULT,
    localparam int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);

    localparam int N = WIDTH / DIGIT;

    serial_alu_state_t state;
    alu_op_t           op_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  work_q;
    logic              carry_q;
    logic              a_msb_q;
    logic              b_msb_q;
    logic              shift_en_q;
    logic [SHW-1:0]    count_q;

    logic              sub_mode;
    logic [DIGIT-1:0]  sum_digit;
    logic [DIGIT-1:0]  digit_out;
    logic              carry_out;
    logic [WIDTH-1:0]  arith_next;
    logic [WIDTH-1:0]  arith_final;
    logic [WIDTH-1:0]  shift_next;
    logic [SHW-1:0]    shift_amt;

    assign shift_amt = b[SHW-1:0];
    assign sub_mode  = is_sub_op(op_q);

    // Cycles spent in SHIFT: one per bit moved, at least 1, at most WIDTH.
    function automatic logic [SHW-1:0] shift_cycles(input logic [SHW-1:0] amt);
        if (amt == '0)
            return SHW'(1);
        else if (amt >= SHW'(WIDTH))
            return SHW'(WIDTH);
        else
            return amt;
    endfunction

    serial_digit_adder #(.DIGIT(DIGIT)) u_adder (
        .a         (a_q[DIGIT-1:0]),
        .b         (b_q[DIGIT-1:0]),
        .invert_b  (sub_mode),
        .carry_in  (carry_q),
        .sum       (sum_digit),
        .carry_out (carry_out)
    );

    // Next digit of the result, final compare value, and the next one-bit shift step.
    always_comb begin
        digit_out = sum_digit;
        case (op_q)
            ALU_AND: digit_out = a_q[DIGIT-1:0] & b_q[DIGIT-1:0];
            ALU_OR:  digit_out = a_q[DIGIT-1:0] | b_q[DIGIT-1:0];
            ALU_XOR: digit_out = a_q[DIGIT-1:0] ^ b_q[DIGIT-1:0];
            default: ;
        endcase

        arith_next  = {digit_out, work_q[WIDTH-1:DIGIT]};
        arith_final = arith_next;
        case (op_q)
            ALU_SLTU: arith_final = {{(WIDTH-1){1'b0}}, ~carry_out};
            ALU_SLT:  arith_final = {{(WIDTH-1){1'b0}},
                                     (a_msb_q != b_msb_q) ? a_msb_q : sum_digit[DIGIT-1]};
            default: ;
        endcase

        shift_next = work_q;
        if (shift_en_q) begin
            case (op_q)
                ALU_SLL: shift_next = {work_q[WIDTH-2:0], 1'b0};
                ALU_SRL: shift_next = {1'b0, work_q[WIDTH-1:1]};
                ALU_SRA: shift_next = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                default: ;
            endcase
        end
    end

    // Control FSM plus operand/working registers; done/illegal/result are registered on entry to FIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= ALU_ADD;
            a_q        <= '0;
            b_q        <= '0;
            work_q     <= '0;
            carry_q    <= 1'b0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            shift_en_q <= 1'b0;
            count_q    <= '0;
            ready      <= 1'b1;
            done       <= 1'b0;
            illegal    <= 1'b0;
            result     <= '0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        op_q       <= op;
                        a_q        <= a;
                        b_q        <= b;
                        work_q     <= a;
                        a_msb_q    <= a[WIDTH-1];
                        b_msb_q    <= b[WIDTH-1];
                        carry_q    <= is_sub_op(op);
                        shift_en_q <= (shift_amt != '0);
                        ready      <= 1'b0;
                        if (!is_legal_op(op)) begin
                            state   <= FIN;
                            result  <= '0;
                            done    <= 1'b1;
                            illegal <= 1'b1;
                        end else begin
                            case (op)
                                ALU_LUI: begin
                                    state  <= FIN;
                                    result <= b;
                                    done   <= 1'b1;
                                end
                                ALU_SLL, ALU_SRL, ALU_SRA: begin
                                    state   <= SHIFT;
                                    count_q <= shift_cycles(shift_amt);
                                end
                                default: begin
                                    state   <= ARITH;
                                    count_q <= SHW'(N);
                                end
                            endcase
                        end
                    end
                end
                ARITH: begin
                    if (flush) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        a_q     <= a_q >> DIGIT;
                        b_q     <= b_q >> DIGIT;
                        carry_q <= carry_out;
                        work_q  <= arith_next;
                        count_q <= count_q - SHW'(1);
                        if (count_q == SHW'(1)) begin
                            state  <= FIN;
                            result <= arith_final;
                            done   <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (flush) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        work_q  <= shift_next;
                        count_q <= count_q - SHW'(1);
                        if (count_q == SHW'(1)) begin
                            state  <= FIN;
                            result <= shift_next;
                            done   <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// Directed self-checking bench for serial_alu at WIDTH=16, DIGIT=4.
module tb_serial_alu;
    import serial_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    alu_op_t     op;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        done;
    logic [15:0] result;
    logic        illegal;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;
    int t0;

    serial_alu #(.WIDTH(16), .DIGIT(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .flush   (flush),
        .op      (op),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .result  (result),
        .illegal (illegal)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Cycle index: the interval after the k-th rising edge is cycle k.
    always @(posedge clk) cycle++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request for exactly one cycle; t0 is the cycle in which start was high.
    task automatic applyStimulus(input alu_op_t o, input logic [15:0] av, input logic [15:0] bv,
                                 output int start_cycle);
        @(negedge clk);
        op    = o;
        a     = av;
        b     = bv;
        start = 1'b1;
        start_cycle = cycle;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done, then check latency, result, illegal and the ready handshake.
    task automatic waitDone(input string tag, input int start_cycle, input int lat,
                            input logic [15:0] exp_res, input logic exp_ill);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1'b1;
            else checkOutput({tag, "_ready_busy"}, 32'(ready), 0);
        end
        checkOutput({tag, "_done_seen"}, 32'(seen), 1);
        if (seen) begin
            checkOutput({tag, "_latency"}, 32'(cycle - start_cycle), 32'(lat));
            checkOutput({tag, "_result"}, 32'(result), 32'(exp_res));
            checkOutput({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
            checkOutput({tag, "_ready_fin"}, 32'(ready), 0);
        end
        @(negedge clk);
        checkOutput({tag, "_ready_after"}, 32'(ready), 1);
        checkOutput({tag, "_done_after"}, 32'(done), 0);
    endtask

    task automatic runOp(input string tag, input alu_op_t o, input logic [15:0] av,
                         input logic [15:0] bv, input int lat, input logic [15:0] exp_res,
                         input logic exp_ill);
        int sc;
        applyStimulus(o, av, bv, sc);
        waitDone(tag, sc, lat, exp_res, exp_ill);
    endtask

    // Confirm that done stays low for a number of cycles.
    task automatic expectQuiet(input string tag, input int ncycles);
        bit saw = 1'b0;
        for (int i = 0; i < ncycles; i++) begin
            @(negedge clk);
            if (done !== 1'b0) saw = 1'b1;
        end
        checkOutput(tag, 32'(saw), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = ALU_ADD;
        a     = '0;
        b     = '0;
        #12;
        checkOutput("rst_ready", 32'(ready), 1);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_result", 32'(result), 0);
        checkOutput("rst_illegal", 32'(illegal), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] arithmetic and compare");
        runOp("add",    ALU_ADD,   16'h00FF, 16'h0001, 5, 16'h0100, 1'b0);
        runOp("sub",    ALU_SUB,   16'h0000, 16'h0001, 5, 16'hFFFF, 1'b0);
        runOp("slt1",   ALU_SLT,   16'h8000, 16'h0001, 5, 16'h0001, 1'b0);
        runOp("sltu1",  ALU_SLTU,  16'h8000, 16'h0001, 5, 16'h0000, 1'b0);
        runOp("slt2",   ALU_SLT,   16'h7FFF, 16'hFFFF, 5, 16'h0000, 1'b0);
        runOp("sltu2",  ALU_SLTU,  16'h0001, 16'h8000, 5, 16'h0001, 1'b0);
        runOp("auipc",  ALU_AUIPC, 16'h1234, 16'h1111, 5, 16'h2345, 1'b0);
        runOp("and",    ALU_AND,   16'hF0F0, 16'hFF00, 5, 16'hF000, 1'b0);
        runOp("or",     ALU_OR,    16'hF0F0, 16'hFF00, 5, 16'hFFF0, 1'b0);

        $display("[TB] shifts");
        runOp("sra_sat", ALU_SRA, 16'h8000, 16'h0013, 17, 16'hFFFF, 1'b0);
        runOp("srl3",    ALU_SRL, 16'h8000, 16'h0003, 4,  16'h1000, 1'b0);
        runOp("sll0",    ALU_SLL, 16'h1234, 16'h0020, 2,  16'h1234, 1'b0);
        runOp("sll4",    ALU_SLL, 16'h0001, 16'h0004, 5,  16'h0010, 1'b0);
        runOp("sll_sat", ALU_SLL, 16'hFFFF, 16'h0010, 17, 16'h0000, 1'b0);

        $display("[TB] illegal and lui");
        runOp("illegal", alu_op_t'(4'hD), 16'h5555, 16'h6666, 1, 16'h0000, 1'b1);
        runOp("lui",     ALU_LUI,         16'h1111, 16'hABCD, 1, 16'hABCD, 1'b0);

        $display("[TB] start while busy");
        applyStimulus(ALU_ADD, 16'h0002, 16'h0003, t0);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = ALU_SUB;
        a     = 16'h0009;
        b     = 16'h0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone("busy_add", t0, 5, 16'h0005, 1'b0);
        expectQuiet("busy_not_queued", 8);

        $display("[TB] flush mid-operation");
        applyStimulus(ALU_ADD, 16'h1111, 16'h2222, t0);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_cycle", 32'(cycle - t0), 3);
        checkOutput("flush_ready", 32'(ready), 1);
        checkOutput("flush_done", 32'(done), 0);
        checkOutput("flush_result_kept", 32'(result), 32'h0005);
        expectQuiet("flush_no_done", 8);

        $display("[TB] start with flush in idle");
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = ALU_ADD;
        a     = 16'h0001;
        b     = 16'h0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("startflush_ready", 32'(ready), 1);
        expectQuiet("startflush_no_done", 8);
        checkOutput("startflush_result", 32'(result), 32'h0005);

        $display("[TB] async reset mid-operation");
        applyStimulus(ALU_XOR, 16'hFFFF, 16'h0F0F, t0);
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("xor_busy_ready", 32'(ready), 0);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_ready", 32'(ready), 1);
        checkOutput("arst_done", 32'(done), 0);
        checkOutput("arst_result", 32'(result), 0);
        checkOutput("arst_illegal", 32'(illegal), 0);
        @(negedge clk);
        rst_n = 1'b1;
        expectQuiet("post_reset_quiet", 6);
        runOp("add_after_rst", ALU_ADD, 16'h1234, 16'h4321, 5, 16'h5555, 1'b0);
        runOp("xor_after_rst", ALU_XOR, 16'hFFFF, 16'h0F0F, 5, 16'hF0F0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
